adc_spi_multi_rx: RTL and testbench

Parametrised multi-channel SPI receiver for serial ADCs of the 12-bit, 16-clock-frame class. The block generates its own active-low chip select `cs_n` and serial clock `sclk` from the system clock. It shifts `CHANNELS` parallel `sdata` lines MSB-first and presents one right-justified sample per channel through a valid/ready handshake. It sits between the ADC pins and the downstream sample processing, and replaces the older single-channel receiver that was clocked directly by an external SCLK.

---
 rtl/adc_pkg.sv | 28 ++
 rtl/adc_sclk_gen.sv | 65 ++++++
 rtl/adc_spi_multi_rx.sv | 197 +++++++++++++++++++
 tb/tb_adc_spi_multi_rx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the multi-channel serial ADC receiver:
//   - adc_state_e : frame sequencer states
//   - DEF_*       : default parameter values for the receiver
//   - cnt_width() : number of bits needed to hold a counter value 0..max_val
// ---------------------------------------------------------------------------
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        QUIET = 2'd3
    } adc_state_e;

    localparam int unsigned DEF_CHANNELS     = 2;
    localparam int unsigned DEF_FRAME_BITS   = 16;
    localparam int unsigned DEF_DATA_BITS    = 12;
    localparam int unsigned DEF_CLK_DIV      = 2;
    localparam int unsigned DEF_QUIET_CYCLES = 4;

    // Width of a counter that must reach max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// ---------------------------------------------------------------------------
// adc_sclk_gen
// Divides clk down to the ADC serial clock. While enabled, sclk toggles
// every CLK_DIV clk cycles starting from its idle-high level; while disabled
// it is held high and the divider is cleared.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   en           : run the divider (SETUP and SHIFT)
//   stop         : on the next half-period tick keep sclk high instead of
//                  driving it low (ends the frame on a high level)
//   sclk         : registered serial clock, idles high
//   sample_stb   : high in the cycle whose closing edge drives sclk 0 -> 1
//   period_done  : high in the cycle whose closing edge ends a high half
// ---------------------------------------------------------------------------
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic stop,
    output logic sclk,
    output logic sample_stb,
    output logic period_done
);

    localparam int unsigned      DIV_W    = cnt_width(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             half_tick;

    always_comb begin
        half_tick = en && (div_q == DIV_LAST);
        div_d     = div_q;
        sclk_d    = sclk_q;
        if (!en) begin
            div_d  = '0;
            sclk_d = 1'b1;
        end else begin
            div_d = half_tick ? '0 : div_q + DIV_W'(1);
            if (half_tick) begin
                sclk_d = stop ? 1'b1 : ~sclk_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk        = sclk_q;
    assign sample_stb  = half_tick && !sclk_q;
    assign period_done = half_tick && sclk_q;

endmodule

// File: rtl/adc_spi_multi_rx.sv
// ---------------------------------------------------------------------------
// adc_spi_multi_rx
// Multi-channel SPI receiver for 12-bit / 16-clock-frame serial ADCs. Drives
// cs_n and sclk itself, shifts CHANNELS sdata lines MSB-first on sclk rising
// edges, and hands one right-justified sample per channel to the consumer
// through a valid/ready handshake.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   start        : request one frame (only looked at in IDLE)
//   continuous   : run frames back to back while high
//   sdata        : one serial data bit per channel
//   cs_n, sclk   : registered ADC chip select (active low) and serial clock
//   data_out     : channel k at [k*DATA_BITS +: DATA_BITS]
//   data_valid   : data_out holds an unconsumed sample set
//   data_ready   : consumer accepts when data_valid && data_ready
//   busy         : sequencer is not in IDLE
//   overrun      : sticky, a new frame replaced an unconsumed sample set
//   overrun_clr  : synchronous clear of overrun (a simultaneous set wins)
// ---------------------------------------------------------------------------
module adc_spi_multi_rx
    import adc_pkg::*;
#(
    parameter int unsigned CHANNELS     = DEF_CHANNELS,
    parameter int unsigned FRAME_BITS   = DEF_FRAME_BITS,
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned QUIET_CYCLES = DEF_QUIET_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          continuous,
    input  logic [CHANNELS-1:0]           sdata,
    output logic                          cs_n,
    output logic                          sclk,
    output logic [CHANNELS*DATA_BITS-1:0] data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int unsigned      BIT_W      = cnt_width(FRAME_BITS);
    localparam int unsigned      QUIET_W    = cnt_width(QUIET_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

    adc_state_e                    state_q, state_d;
    logic [BIT_W-1:0]              bit_cnt_q, bit_cnt_d;
    logic [QUIET_W-1:0]            quiet_cnt_q, quiet_cnt_d;
    logic                          cs_n_q, cs_n_d;
    logic [CHANNELS*DATA_BITS-1:0] data_out_q, data_out_d;
    logic                          data_valid_q, data_valid_d;
    logic                          overrun_q, overrun_d;

    logic                          sclk_en;
    logic                          sample_stb;
    logic                          period_done;
    logic                          shift_en;
    logic                          frame_end;
    logic [CHANNELS*DATA_BITS-1:0] frame_lo;

    // The frame ends when the high half of the last SCLK period has elapsed,
    // i.e. FRAME_BITS samples were taken and the line is back at its idle
    // level. The sample set is committed at that edge, together with cs_n
    // being released.
    assign sclk_en   = (state_q == SETUP) || (state_q == SHIFT);
    assign shift_en  = (state_q == SHIFT) && sample_stb;
    assign frame_end = (state_q == SHIFT) && period_done && (bit_cnt_q == BIT_LAST);

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .reset       (reset),
        .en          (sclk_en),
        .stop        (frame_end),
        .sclk        (sclk),
        .sample_stb  (sample_stb),
        .period_done (period_done)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        cs_n_d      = cs_n_q;
        case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                end
            end
            SETUP: begin
                // First half-period tick in SETUP drives the first sclk fall.
                if (period_done) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (sample_stb) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
                if (frame_end) begin
                    state_d     = QUIET;
                    cs_n_d      = 1'b1;
                    quiet_cnt_d = '0;
                end
            end
            QUIET: begin
                if (quiet_cnt_q == QUIET_LAST) begin
                    if (continuous) begin
                        state_d = SETUP;
                        cs_n_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    quiet_cnt_d = quiet_cnt_q + QUIET_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            cs_n_q      <= cs_n_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [FRAME_BITS-1:0] sh_q, sh_d;
        logic                  unused_msb;

        always_comb begin
            sh_d = sh_q;
            if (shift_en) begin
                sh_d = {sh_q[FRAME_BITS-2:0], sdata[k]};
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sh_q <= '0;
            end else begin
                sh_q <= sh_d;
            end
        end

        // Leading frame bits beyond DATA_BITS are the ADC's zero/pad bits.
        assign frame_lo[k*DATA_BITS +: DATA_BITS] = sh_q[DATA_BITS-1:0];
        assign unused_msb                         = sh_q[FRAME_BITS-1];
    end

    // A new frame takes priority over a same-cycle handshake; overwriting a
    // sample set nobody has taken raises the sticky overrun flag.
    always_comb begin
        data_out_d   = frame_end ? frame_lo : data_out_q;
        data_valid_d = frame_end || (data_valid_q && !data_ready);
        overrun_d    = (frame_end && data_valid_q && !data_ready) ||
                       (overrun_q && !overrun_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cs_n       = cs_n_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adc_spi_multi_rx.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_multi_rx
// Directed bench for adc_spi_multi_rx: a default-parameter instance (2 ch,
// 16-bit frames, CLK_DIV=2) and a swept instance (4 ch, 14-bit frames,
// CLK_DIV=1). Each ADC is modelled as a shifter that presents the next frame
// bit after every sclk falling edge while cs_n is low.
// ---------------------------------------------------------------------------
module tb_adc_spi_multi_rx;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default instance
    logic        start_a = 1'b0, continuous_a = 1'b0, ready_a = 1'b0, clr_a = 1'b0;
    logic [1:0]  sdata_a;
    logic        cs_n_a, sclk_a, valid_a, busy_a, ovr_a;
    logic [23:0] dout_a;

    // Swept instance
    logic        start_b = 1'b0, continuous_b = 1'b0, ready_b = 1'b0, clr_b = 1'b0;
    logic [3:0]  sdata_b;
    logic        cs_n_b, sclk_b, valid_b, busy_b, ovr_b;
    logic [55:0] dout_b;

    adc_spi_multi_rx dut_a (
        .clk         (clk),
        .reset       (reset),
        .start       (start_a),
        .continuous  (continuous_a),
        .sdata       (sdata_a),
        .cs_n        (cs_n_a),
        .sclk        (sclk_a),
        .data_out    (dout_a),
        .data_valid  (valid_a),
        .data_ready  (ready_a),
        .busy        (busy_a),
        .overrun     (ovr_a),
        .overrun_clr (clr_a)
    );

    adc_spi_multi_rx #(
        .CHANNELS     (4),
        .FRAME_BITS   (14),
        .DATA_BITS    (14),
        .CLK_DIV      (1),
        .QUIET_CYCLES (4)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .start       (start_b),
        .continuous  (continuous_b),
        .sdata       (sdata_b),
        .cs_n        (cs_n_b),
        .sclk        (sclk_b),
        .data_out    (dout_b),
        .data_valid  (valid_b),
        .data_ready  (ready_b),
        .busy        (busy_b),
        .overrun     (ovr_b),
        .overrun_clr (clr_b)
    );

    // ADC models
    logic [15:0] pat_a [2];
    logic [13:0] pat_b [4];
    int          fall_a = 0;
    int          fall_b = 0;

    function automatic logic pick(input logic [15:0] w, input int n);
        logic [15:0] s;
        s = w >> n;
        return s[0];
    endfunction

    always @(negedge sclk_a or posedge cs_n_a) begin
        if (cs_n_a) fall_a = 0;
        else        fall_a = fall_a + 1;
    end

    always @(negedge sclk_b or posedge cs_n_b) begin
        if (cs_n_b) fall_b = 0;
        else        fall_b = fall_b + 1;
    end

    always_comb begin
        sdata_a = '0;
        for (int k = 0; k < 2; k++) begin
            if (fall_a >= 1 && fall_a <= 16) sdata_a[k] = pick(pat_a[k], 16 - fall_a);
        end
    end

    always_comb begin
        sdata_b = '0;
        for (int k = 0; k < 4; k++) begin
            if (fall_b >= 1 && fall_b <= 14) sdata_b[k] = pick(16'(pat_b[k]), 14 - fall_b);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
    endtask

    // n = edges after the call until valid is seen (-1 if never);
    // falls = model fall count one cycle before valid.
    task automatic wait_valid_a(output int n, output int falls);
        n     = -1;
        falls = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (valid_a) begin
                n = i;
                break;
            end
            falls = fall_a;
        end
    endtask

    task automatic wait_valid_b(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (valid_b) begin
                n = i;
                break;
            end
        end
    endtask

    logic [13:0] sw [4][4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, falls;
        int t [3];

        pat_a[0] = '0; pat_a[1] = '0;
        for (int k = 0; k < 4; k++) pat_b[k] = '0;

        // Reset state
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cs_n",  64'(cs_n_a),  64'(1));
        check("rst_sclk",  64'(sclk_a),  64'(1));
        check("rst_valid", 64'(valid_a), 64'(0));
        check("rst_dout",  64'(dout_a),  64'(0));
        check("rst_busy",  64'(busy_a),  64'(0));
        check("rst_ovr",   64'(ovr_a),   64'(0));
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);

        // Single frame, defaults
        pat_a[0] = 16'h0ABC;
        pat_a[1] = 16'h0123;
        pulse_start_a();
        check("t1_cs_low", 64'(cs_n_a), 64'(0));
        check("t1_busy",   64'(busy_a), 64'(1));
        wait_valid_a(n, falls);
        check("t1_latency", 64'(n),      64'(66));
        check("t1_falls",   64'(falls),  64'(16));
        check("t1_dout",    64'(dout_a), 64'(24'h123ABC));
        check("t1_cs_high", 64'(cs_n_a), 64'(1));
        check("t1_sclk_hi", 64'(sclk_a), 64'(1));
        @(negedge clk) ready_a = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b0;
        check("t1_hs_clear", 64'(valid_a), 64'(0));
        repeat (6) @(posedge clk);
        #1;
        check("t1_idle", 64'(busy_a), 64'(0));

        // Continuous, consumer always ready
        ready_a  = 1'b1;
        pat_a[0] = 16'hF000 | 16'h0111;
        pat_a[1] = 16'hE000 | 16'h0222;
        @(negedge clk) continuous_a = 1'b1;
        @(posedge clk);
        #1;
        for (int f = 0; f < 3; f++) begin
            wait_valid_a(n, falls);
            t[f] = cyc;
            if (f == 0) check("t2_latency0", 64'(n), 64'(66));
            else        check("t2_period",   64'(t[f] - t[f-1]), 64'(70));
            check("t2_dout", 64'(dout_a), 64'({12'(12'h222 * (f + 1)), 12'(12'h111 * (f + 1))}));
            pat_a[0] = 16'hF000 | 16'(12'h111 * (f + 2));
            pat_a[1] = 16'hE000 | 16'(12'h222 * (f + 2));
            if (f == 2) continuous_a = 1'b0;
            @(posedge clk);
            #1;
            check("t2_pulse_end", 64'(valid_a), 64'(0));
        end
        check("t2_ovr", 64'(ovr_a), 64'(0));
        repeat (8) @(posedge clk);
        #1;
        check("t2_idle", 64'(busy_a), 64'(0));

        // Overrun: two frames, nobody consuming
        ready_a  = 1'b0;
        pat_a[0] = 16'h0F0F;
        pat_a[1] = 16'h0A5A;
        @(negedge clk) continuous_a = 1'b1;
        @(posedge clk);
        #1;
        wait_valid_a(n, falls);
        check("t3_latency", 64'(n),      64'(66));
        check("t3_dout_a",  64'(dout_a), 64'(24'hA5AF0F));
        check("t3_ovr0",    64'(ovr_a),  64'(0));
        pat_a[0] = 16'h0C3C;
        pat_a[1] = 16'h0765;
        repeat (69) @(posedge clk);
        #1;
        check("t3_ovr_pre",  64'(ovr_a),  64'(0));
        check("t3_dout_pre", 64'(dout_a), 64'(24'hA5AF0F));
        @(posedge clk);
        #1;
        continuous_a = 1'b0;
        check("t3_ovr_set", 64'(ovr_a),   64'(1));
        check("t3_dout_b",  64'(dout_a),  64'(24'h765C3C));
        check("t3_valid",   64'(valid_a), 64'(1));
        @(negedge clk) clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        check("t3_ovr_clr",  64'(ovr_a),   64'(0));
        check("t3_valid_kept", 64'(valid_a), 64'(1));
        repeat (6) @(posedge clk);

        // Reset during bit 7 of SHIFT
        pat_a[0] = 16'h0555;
        pat_a[1] = 16'h0AAA;
        pulse_start_a();
        repeat (30) @(posedge clk);
        #3;
        check("t4_mid_cs",   64'(cs_n_a), 64'(0));
        check("t4_mid_sclk", 64'(sclk_a), 64'(0));
        check("t4_mid_busy", 64'(busy_a), 64'(1));
        reset = 1'b1;
        #1;
        check("t4_rst_cs",    64'(cs_n_a),  64'(1));
        check("t4_rst_sclk",  64'(sclk_a),  64'(1));
        check("t4_rst_valid", 64'(valid_a), 64'(0));
        check("t4_rst_dout",  64'(dout_a),  64'(0));
        check("t4_rst_busy",  64'(busy_a),  64'(0));
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);
        pat_a[0] = 16'h0FED;
        pat_a[1] = 16'h0321;
        pulse_start_a();
        wait_valid_a(n, falls);
        check("t4_latency", 64'(n),      64'(66));
        check("t4_falls",   64'(falls),  64'(16));
        check("t4_dout",    64'(dout_a), 64'(24'h321FED));
        check("t4_ovr",     64'(ovr_a),  64'(0));
        @(negedge clk) ready_a = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b0;

        // Swept instance: 4 channels, 14-bit frames, CLK_DIV=1
        for (int k = 0; k < 4; k++) begin
            sw[0][k] = 14'h3FFF;
            sw[1][k] = 14'h0000;
            sw[2][k] = k[0] ? 14'h1555 : 14'h2AAA;
        end
        sw[3][0] = 14'h0001;
        sw[3][1] = 14'h2000;
        sw[3][2] = 14'h1234;
        sw[3][3] = 14'h3210;
        ready_b = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) pat_b[k] = sw[f][k];
            pulse_start_b();
            wait_valid_b(n);
            check("t5_latency", 64'(n), 64'(29));
            check("t5_dout", 64'(dout_b), 64'({sw[f][3], sw[f][2], sw[f][1], sw[f][0]}));
            repeat (6) @(posedge clk);
            #1;
            check("t5_idle", 64'(busy_b), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
